// File: rtl/riscv_pkg.sv
// Package: riscv_pkg
// Shared types and constants for the retire trace sink.
//   XLEN          architectural register / address width
//   RETIRE_SEQ_W  width of the per-record sequence number
//   retire_rec_t  one retired instruction as stored in the trace FIFO
//   is_branch_or_jump()  true for BRANCH, JAL and JALR opcodes
package riscv_pkg;

  localparam int XLEN         = 32;
  localparam int RETIRE_SEQ_W = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [RETIRE_SEQ_W-1:0] seq;
    logic [XLEN-1:0]         pc;
    logic [XLEN-1:0]         instr;
    logic [4:0]              reg_addr;
    logic [XLEN-1:0]         reg_data;
    logic [XLEN-1:0]         mem_addr;
    logic [XLEN-1:0]         mem_data;
    logic                    mem_wrt;
  } retire_rec_t;

  function automatic logic is_branch_or_jump(input logic [XLEN-1:0] instr);
    return (instr[6:0] == OPC_BRANCH) || (instr[6:0] == OPC_JAL) ||
           (instr[6:0] == OPC_JALR);
  endfunction

endpackage

// File: rtl/retire_fifo_2w1r.sv
// Module: retire_fifo_2w1r
// Record FIFO with up to two writes and one first-word-fall-through read per
// cycle. The caller packs writes: wr_cnt=1 writes wr_data0, wr_cnt=2 writes
// wr_data0 then wr_data1. The caller guarantees there is room for wr_cnt
// entries and only asserts rd_en while valid is high.
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_cnt [1:0]        number of records written this cycle (0..2)
//   wr_data0, wr_data1  records in program order
//   rd_en               head is consumed on this edge
//   rd_data             head record (meaningful while valid)
//   valid               FIFO non-empty
//   level               occupancy, 0..Depth
module retire_fifo_2w1r
  import riscv_pkg::*;
#(
  parameter int Depth = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               wr_cnt,
  input  retire_rec_t              wr_data0,
  input  retire_rec_t              wr_data1,
  input  logic                     rd_en,
  output retire_rec_t              rd_data,
  output logic                     valid,
  output logic [$clog2(Depth):0]   level
);

  localparam int AW = $clog2(Depth);
  localparam int LW = AW + 1;

  retire_rec_t    mem [Depth];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;

  // NOTE: storage has no reset; only pointers and level decide which entries
  // are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_cnt != 2'd0) mem[wptr]          <= wr_data0;
    if (wr_cnt == 2'd2) mem[wptr + AW'(1)] <= wr_data1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      wptr  <= wptr + AW'(wr_cnt);
      rptr  <= rptr + AW'(rd_en);
      level <= level + LW'(wr_cnt) - LW'(rd_en);
    end
  end

  assign rd_data = mem[rptr];
  assign valid   = (level != '0);

endmodule

// File: rtl/retire_trace_sink.sv
// Module: retire_trace_sink
// Captures up to two retire records per cycle in program order, stamps each
// with a sequence number and replays them one per cycle on a valid/ready
// trace stream. A cycle whose records do not all fit is dropped whole and
// counted. Optional macro RETIRE_ORDER_CHK_EN builds a sticky slot-order check.
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   update_i..mem_wrt_i  per-slot retire interface (IssueWidth slots)
//   trace_valid_o/ready_i/rec_o  FWFT trace stream, record includes seq
//   level_o              FIFO occupancy
//   overflow_o           sticky: a cycle was dropped
//   drop_cnt_o           saturating count of dropped records
//   order_err_o          sticky order error (0 without RETIRE_ORDER_CHK_EN)
module retire_trace_sink
  import riscv_pkg::*;
#(
  parameter int IssueWidth = 2,
  parameter int Depth      = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic [IssueWidth-1:0]                update_i,
  input  logic [IssueWidth-1:0][XLEN-1:0]      pc_i,
  input  logic [IssueWidth-1:0][XLEN-1:0]      instr_i,
  input  logic [IssueWidth-1:0][4:0]           reg_addr_i,
  input  logic [IssueWidth-1:0][XLEN-1:0]      reg_data_i,
  input  logic [IssueWidth-1:0][XLEN-1:0]      mem_addr_i,
  input  logic [IssueWidth-1:0][XLEN-1:0]      mem_data_i,
  input  logic [IssueWidth-1:0]                mem_wrt_i,
  output logic                                 trace_valid_o,
  input  logic                                 trace_ready_i,
  output retire_rec_t                          trace_rec_o,
  output logic [$clog2(Depth):0]               level_o,
  output logic                                 overflow_o,
  output logic [15:0]                          drop_cnt_o,
  output logic                                 order_err_o
);

  localparam int LW = $clog2(Depth) + 1;

  logic [RETIRE_SEQ_W-1:0] seq_q;
  logic [1:0]              n;
  logic [LW-1:0]           free;
  logic                    accept;
  logic [1:0]              wr_cnt;
  logic                    pop;
  logic [16:0]             drop_sum;
  retire_rec_t             recs [2];
  retire_rec_t             wr_data0;

  assign n      = {1'b0, update_i[0]} + {1'b0, update_i[1]};
  // Space is judged on registered occupancy only; a same-cycle pop does not help.
  assign free   = LW'(Depth) - level_o;
  assign accept = (LW'(n) <= free);
  assign wr_cnt = accept ? n : 2'd0;
  assign pop    = trace_valid_o && trace_ready_i;

  // NOTE: every always_comb output gets a full assignment on every path so
  // no latch is inferred.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      recs[s].seq      = seq_q;
      recs[s].pc       = pc_i[s];
      recs[s].instr    = instr_i[s];
      recs[s].reg_addr = reg_addr_i[s];
      recs[s].reg_data = reg_data_i[s];
      recs[s].mem_addr = mem_addr_i[s];
      recs[s].mem_data = mem_data_i[s];
      recs[s].mem_wrt  = mem_wrt_i[s];
    end
    // Slot 1 takes the next number only when slot 0 also retired.
    recs[1].seq = seq_q + RETIRE_SEQ_W'(update_i[0]);
    // A lone slot-1 retire is packed into the first write port.
    wr_data0    = update_i[0] ? recs[0] : recs[1];
  end

  retire_fifo_2w1r #(.Depth(Depth)) u_fifo (
    .clk      (clk_i),
    .rst_n    (rstn_i),
    .wr_cnt   (wr_cnt),
    .wr_data0 (wr_data0),
    .wr_data1 (recs[1]),
    .rd_en    (pop),
    .rd_data  (trace_rec_o),
    .valid    (trace_valid_o),
    .level    (level_o)
  );

  assign drop_sum = {1'b0, drop_cnt_o} + 17'(n);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      seq_q      <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (accept) begin
      seq_q <= seq_q + RETIRE_SEQ_W'(wr_cnt);
    end else begin
      overflow_o <= 1'b1;
      drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

`ifdef RETIRE_ORDER_CHK_EN
  logic order_bad;

  assign order_bad = (update_i[1] && !update_i[0]) ||
                     (update_i[1] && update_i[0] &&
                      (pc_i[1] != pc_i[0] + XLEN'(4)) &&
                      !is_branch_or_jump(instr_i[0]));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)        order_err_o <= 1'b0;
    else if (order_bad) order_err_o <= 1'b1;
  end
`else
  assign order_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_retire_trace_sink.sv
// Testbench: tb_retire_trace_sink
// Drives retire_trace_sink with directed and $urandom stimulus and compares
// every cycle against a queue-based reference model of the trace sink.
// Honours RETIRE_ORDER_CHK_EN to choose the expected order_err_o behaviour.
module tb_retire_trace_sink;
  import riscv_pkg::*;

  localparam int DEPTH = 16;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic [1:0]        update_i;
  logic [1:0][31:0]  pc_i;
  logic [1:0][31:0]  instr_i;
  logic [1:0][4:0]   reg_addr_i;
  logic [1:0][31:0]  reg_data_i;
  logic [1:0][31:0]  mem_addr_i;
  logic [1:0][31:0]  mem_data_i;
  logic [1:0]        mem_wrt_i;
  logic              trace_valid_o;
  logic              trace_ready_i;
  retire_rec_t       trace_rec_o;
  logic [4:0]        level_o;
  logic              overflow_o;
  logic [15:0]       drop_cnt_o;
  logic              order_err_o;

  int total = 0;
  int bad   = 0;

  // Reference model state
  retire_rec_t model_q[$];
  logic [31:0] model_seq;
  bit          exp_ovf;
  int          exp_drop;
  bit          exp_oerr;

  retire_trace_sink #(.IssueWidth(2), .Depth(DEPTH)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .update_i      (update_i),
    .pc_i          (pc_i),
    .instr_i       (instr_i),
    .reg_addr_i    (reg_addr_i),
    .reg_data_i    (reg_data_i),
    .mem_addr_i    (mem_addr_i),
    .mem_data_i    (mem_data_i),
    .mem_wrt_i     (mem_wrt_i),
    .trace_valid_o (trace_valid_o),
    .trace_ready_i (trace_ready_i),
    .trace_rec_o   (trace_rec_o),
    .level_o       (level_o),
    .overflow_o    (overflow_o),
    .drop_cnt_o    (drop_cnt_o),
    .order_err_o   (order_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic retire_rec_t mk_rec(input int s, input logic [31:0] sq);
    retire_rec_t r;
    r.seq      = sq;
    r.pc       = pc_i[s];
    r.instr    = instr_i[s];
    r.reg_addr = reg_addr_i[s];
    r.reg_data = reg_data_i[s];
    r.mem_addr = mem_addr_i[s];
    r.mem_data = mem_data_i[s];
    r.mem_wrt  = mem_wrt_i[s];
    return r;
  endfunction

  task automatic rand_payload();
    for (int s = 0; s < 2; s++) begin
      pc_i[s]       = $urandom;
      instr_i[s]    = $urandom;
      reg_addr_i[s] = 5'($urandom);
      reg_data_i[s] = $urandom;
      mem_addr_i[s] = $urandom;
      mem_data_i[s] = $urandom;
      mem_wrt_i[s]  = 1'($urandom);
    end
  endtask

  task automatic reset_dut();
    update_i      = '0;
    trace_ready_i = 1'b0;
    rstn_i        = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    model_q.delete();
    model_seq = '0;
    exp_ovf   = 0;
    exp_drop  = 0;
    exp_oerr  = 0;
  endtask

  // One clock: apply upd/rdy with the current payload, advance the model by
  // the stated rules, then compare every observable output after the edge.
  task automatic cycle(input logic [1:0] upd, input logic rdy);
    int n;
    bit pop;
    bit fits;
    update_i      = upd;
    trace_ready_i = rdy;
    n    = int'(upd[0]) + int'(upd[1]);
    pop  = (model_q.size() != 0) && rdy;
    fits = (DEPTH - model_q.size()) >= n;
`ifdef RETIRE_ORDER_CHK_EN
    if (upd == 2'b10) exp_oerr = 1;
    if (upd == 2'b11 && pc_i[1] != pc_i[0] + 32'd4 &&
        !(instr_i[0][6:0] inside {7'b1100011, 7'b1101111, 7'b1100111}))
      exp_oerr = 1;
`endif
    if (pop) void'(model_q.pop_front());
    if (fits) begin
      for (int s = 0; s < 2; s++)
        if (upd[s]) begin
          model_q.push_back(mk_rec(s, model_seq));
          model_seq = model_seq + 32'd1;
        end
    end else begin
      exp_ovf  = 1;
      exp_drop = (exp_drop + n > 65535) ? 65535 : exp_drop + n;
    end
    @(posedge clk_i);
    #1;
    update_i      = '0;
    trace_ready_i = 1'b0;
    total++;
    if (trace_valid_o !== (model_q.size() != 0)) begin
      bad++;
      $display("FAIL valid: got %b expected %b", trace_valid_o, model_q.size() != 0);
    end
    total++;
    if (level_o !== 5'(model_q.size())) begin
      bad++;
      $display("FAIL level: got %0d expected %0d", level_o, model_q.size());
    end
    total++;
    if (overflow_o !== exp_ovf) begin
      bad++;
      $display("FAIL overflow: got %b expected %b", overflow_o, exp_ovf);
    end
    total++;
    if (drop_cnt_o !== 16'(exp_drop)) begin
      bad++;
      $display("FAIL drop_cnt: got %0d expected %0d", drop_cnt_o, exp_drop);
    end
    total++;
    if (order_err_o !== exp_oerr) begin
      bad++;
      $display("FAIL order_err: got %b expected %b", order_err_o, exp_oerr);
    end
    if (model_q.size() != 0) begin
      total++;
      if (trace_rec_o !== model_q[0]) begin
        bad++;
        $display("FAIL head_rec: got %h expected %h", trace_rec_o, model_q[0]);
      end
    end
  endtask

  task automatic test_reset();
    update_i      = '0;
    trace_ready_i = 1'b0;
    rand_payload();
    rstn_i = 1'b0;
    #2;
    total++;
    if ({trace_valid_o, level_o, overflow_o, drop_cnt_o, order_err_o} !== 23'd0) begin
      bad++;
      $display("FAIL reset_state: got v=%b lvl=%0d ovf=%b drop=%0d oerr=%b expected all 0",
               trace_valid_o, level_o, overflow_o, drop_cnt_o, order_err_o);
    end
    reset_dut();
  endtask

  task automatic test_basic();
    reset_dut();
    rand_payload();
    pc_i[0] = 32'h100;
    pc_i[1] = 32'h104;
    cycle(2'b11, 1'b1);
    total++;
    if (trace_rec_o.pc !== 32'h100 || trace_rec_o.seq !== 32'd0) begin
      bad++;
      $display("FAIL basic_first: got pc=%h seq=%0d expected pc=100 seq=0",
               trace_rec_o.pc, trace_rec_o.seq);
    end
    cycle(2'b00, 1'b1);
    total++;
    if (trace_rec_o.pc !== 32'h104 || trace_rec_o.seq !== 32'd1) begin
      bad++;
      $display("FAIL basic_second: got pc=%h seq=%0d expected pc=104 seq=1",
               trace_rec_o.pc, trace_rec_o.seq);
    end
    cycle(2'b00, 1'b1);
    total++;
    if (level_o !== 5'd0) begin
      bad++;
      $display("FAIL basic_drain: got level=%0d expected 0", level_o);
    end
  endtask

  task automatic test_full_overflow();
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      rand_payload();
      cycle(2'b11, 1'b0);
    end
    total++;
    if (level_o !== 5'd16 || overflow_o !== 1'b0) begin
      bad++;
      $display("FAIL fill: got level=%0d ovf=%b expected 16/0", level_o, overflow_o);
    end
    rand_payload();
    cycle(2'b11, 1'b0);
    total++;
    if (level_o !== 5'd16 || overflow_o !== 1'b1 || drop_cnt_o !== 16'd2) begin
      bad++;
      $display("FAIL overflow_9th: got level=%0d ovf=%b drop=%0d expected 16/1/2",
               level_o, overflow_o, drop_cnt_o);
    end
    // Full FIFO with a same-cycle pop still rejects the push.
    rand_payload();
    cycle(2'b01, 1'b1);
    total++;
    if (level_o !== 5'd15 || drop_cnt_o !== 16'd3) begin
      bad++;
      $display("FAIL full_pop_push: got level=%0d drop=%0d expected 15/3",
               level_o, drop_cnt_o);
    end
    rand_payload();
    cycle(2'b01, 1'b1);
    total++;
    if (level_o !== 5'd15 || drop_cnt_o !== 16'd3) begin
      bad++;
      $display("FAIL push_pop_15: got level=%0d drop=%0d expected 15/3",
               level_o, drop_cnt_o);
    end
    while (model_q.size() != 0) cycle(2'b00, 1'b1);
  endtask

  task automatic test_random_stream();
    int guard;
    reset_dut();
    guard = 0;
    while (model_seq < 32'd40 && guard < 2000) begin
      rand_payload();
      cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      guard++;
    end
    guard = 0;
    while (model_q.size() != 0 && guard < 100) begin
      cycle(2'b00, 1'($urandom_range(0, 1)));
      guard++;
    end
    total++;
    if (trace_valid_o !== 1'b0 || model_seq < 32'd40) begin
      bad++;
      $display("FAIL random_drain: got valid=%b accepted=%0d expected 0 and >=40",
               trace_valid_o, model_seq);
    end
    // Longer random burst with heavier traffic and back-to-back pushes.
    for (int i = 0; i < 300; i++) begin
      rand_payload();
      cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
    end
  endtask

  task automatic test_mid_reset();
    reset_dut();
    rand_payload();
    cycle(2'b11, 1'b0);
    rand_payload();
    cycle(2'b11, 1'b0);
    rand_payload();
    cycle(2'b01, 1'b0);
    total++;
    if (level_o !== 5'd5) begin
      bad++;
      $display("FAIL pre_reset_level: got %0d expected 5", level_o);
    end
    rstn_i = 1'b0;
    #1;
    total++;
    if (trace_valid_o !== 1'b0 || level_o !== 5'd0) begin
      bad++;
      $display("FAIL async_reset: got valid=%b level=%0d expected 0/0",
               trace_valid_o, level_o);
    end
    reset_dut();
    rand_payload();
    cycle(2'b01, 1'b1);
    total++;
    if (trace_valid_o !== 1'b1 || trace_rec_o.seq !== 32'd0) begin
      bad++;
      $display("FAIL post_reset_seq: got valid=%b seq=%0d expected 1/0",
               trace_valid_o, trace_rec_o.seq);
    end
    cycle(2'b00, 1'b1);
  endtask

  task automatic test_order_check();
    bit want;
`ifdef RETIRE_ORDER_CHK_EN
    want = 1;
`else
    want = 0;
`endif
    reset_dut();
    rand_payload();
    pc_i[0] = 32'h200;
    pc_i[1] = 32'h300;
    instr_i[0] = 32'h0000_0063;   // branch: non-sequential pc is legal
    cycle(2'b11, 1'b1);
    total++;
    if (order_err_o !== 1'b0) begin
      bad++;
      $display("FAIL order_branch_ok: got %b expected 0", order_err_o);
    end
    rand_payload();
    pc_i[0] = 32'h200;
    pc_i[1] = 32'h300;
    instr_i[0] = 32'h0000_0013;   // addi: pc must be sequential
    cycle(2'b11, 1'b1);
    total++;
    if (order_err_o !== want) begin
      bad++;
      $display("FAIL order_pc_gap: got %b expected %b", order_err_o, want);
    end
    while (model_q.size() != 0) cycle(2'b00, 1'b1);
    reset_dut();
    rand_payload();
    pc_i[1] = 32'h400;
    cycle(2'b10, 1'b1);
    total++;
    if (order_err_o !== want || trace_valid_o !== 1'b1 ||
        trace_rec_o.pc !== 32'h400 || trace_rec_o.seq !== 32'd0) begin
      bad++;
      $display("FAIL order_slot1_only: got oerr=%b valid=%b pc=%h seq=%0d expected %b/1/400/0",
               order_err_o, trace_valid_o, trace_rec_o.pc, trace_rec_o.seq, want);
    end
    cycle(2'b00, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_overflow();
    test_random_stream();
    test_mid_reset();
    test_order_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
